// File: rtl/flop_arb_pkg.sv
// Shared types and sizing helpers for the flop_share_arbiter slice.
// Combinational/constant only; no backpressure.
package flop_arb_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    // Wide enough for MAX_BURST up to 15.
    localparam int CNT_W = 4;

    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/flop_share_arbiter_rr_picker.sv
// Round-robin picker: first set request searching circularly from ptr.
// Latency 0 (combinational); no backpressure, pure selection.
module rr_picker #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] win_id,
    output logic [N-1:0]  win_oh,
    output logic          any_req
);

    always_comb begin
        int            idx;
        logic [IW-1:0] sel;
        logic          found;
        win_id = '0;
        win_oh = '0;
        found  = 1'b0;
        idx    = 0;
        sel    = '0;
        for (int k = 0; k < N; k++) begin
            // Wrap modulo N so non-power-of-two N never yields an illegal id.
            idx = int'(ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            sel = IW'(idx);
            if (!found && req[sel]) begin
                found       = 1'b1;
                win_id      = sel;
                win_oh[sel] = 1'b1;
            end
        end
        any_req = found;
    end

endmodule

// File: rtl/flop_share_arbiter.sv
// Shares one external DATA_W register among NUM_REQ requesters (round robin + locked bursts).
// gnt/qin combinational (0 cycles); wr_valid/wr_id 1 cycle later with qout; losers hold req until granted.
module flop_share_arbiter
    import flop_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4,
    localparam int ID_W     = id_w(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        lock,
    input  logic [NUM_REQ*DATA_W-1:0] wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [DATA_W-1:0]         qin,
    input  logic [DATA_W-1:0]         qout,
    output logic                      busy,
    output logic                      wr_valid,
    output logic [ID_W-1:0]           wr_id
);

    arb_state_e       state_q, state_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [ID_W-1:0]  owner_q, owner_d;
    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
    logic             wr_valid_q, wr_valid_d;
    logic [ID_W-1:0]  wr_id_q, wr_id_d;

    logic [ID_W-1:0]    win_id;
    logic [NUM_REQ-1:0] win_oh;
    logic               any_req;
    logic               wr_en;
    logic               burst_end;
    logic [ID_W-1:0]    wr_src;

    function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] id);
        return (id == ID_W'(NUM_REQ - 1)) ? '0 : id + 1'b1;
    endfunction

    rr_picker #(
        .N  (NUM_REQ),
        .IW (ID_W)
    ) u_picker (
        .req     (req),
        .ptr     (ptr_q),
        .win_id  (win_id),
        .win_oh  (win_oh),
        .any_req (any_req)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        burst_cnt_d = burst_cnt_q;
        gnt         = '0;
        qin         = qout;
        wr_en       = 1'b0;
        burst_end   = 1'b0;
        wr_src      = owner_q;

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    gnt    = win_oh;
                    wr_en  = 1'b1;
                    wr_src = win_id;
                    ptr_d  = wrap_inc(win_id);
                    if (lock[win_id] && (MAX_BURST > 1)) begin
                        state_d     = LOCKED;
                        owner_d     = win_id;
                        burst_cnt_d = CNT_W'(1);
                    end
                end
            end
            LOCKED: begin
                gnt[owner_q] = req[owner_q];
                if (req[owner_q]) begin
                    wr_en       = 1'b1;
                    burst_cnt_d = burst_cnt_q + 1'b1;
                    if (!lock[owner_q] || (burst_cnt_d == CNT_W'(MAX_BURST))) begin
                        burst_end = 1'b1;
                    end
                end else if (!lock[owner_q]) begin
                    burst_end = 1'b1;
                end
                // Idle owner holding lock keeps the slot; nothing is written.
                if (burst_end) begin
                    state_d     = IDLE;
                    ptr_d       = wrap_inc(owner_q);
                    burst_cnt_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (wr_en) begin
            qin = wdata[wr_src*DATA_W +: DATA_W];
        end

        wr_valid_d = wr_en;
        wr_id_d    = wr_en ? wr_src : wr_id_q;

        // Clearing qin during reset clears the external register on the same edges.
        if (!reset) begin
            gnt = '0;
            qin = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            owner_q     <= '0;
            burst_cnt_q <= '0;
            wr_valid_q  <= 1'b0;
            wr_id_q     <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            burst_cnt_q <= burst_cnt_d;
            wr_valid_q  <= wr_valid_d;
            wr_id_q     <= wr_id_d;
        end
    end

    assign busy     = (state_q == LOCKED);
    assign wr_valid = wr_valid_q;
    assign wr_id    = wr_id_q;

endmodule

// File: tb/tb_flop_share_arbiter.sv
// Directed bench for flop_share_arbiter with a behavioural 8-bit flipflop on qin/qout.
module tb_flop_share_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [3:0]  lock;
    logic [31:0] wdata;
    logic [3:0]  gnt;
    logic [7:0]  qin;
    logic [7:0]  qout;
    logic        busy;
    logic        wr_valid;
    logic [1:0]  wr_id;

    int n_pass;
    int n_total;

    flop_share_arbiter #(
        .NUM_REQ   (4),
        .DATA_W    (8),
        .MAX_BURST (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .lock     (lock),
        .wdata    (wdata),
        .gnt      (gnt),
        .qin      (qin),
        .qout     (qout),
        .busy     (busy),
        .wr_valid (wr_valid),
        .wr_id    (wr_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The shared register: reloads qin every edge.
    always @(posedge clk) qout <= qin;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        req   = 4'b1111;
        wdata = 32'hFFFF_FFFF;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_total++; if (gnt !== 4'b0000) $display("FAIL rst_gnt c=%0d got %b exp 0000", c, gnt); else n_pass++;
            n_total++; if (qin !== 8'h00) $display("FAIL rst_qin c=%0d got %h exp 00", c, qin); else n_pass++;
            tick();
            n_total++; if (qout !== 8'h00) $display("FAIL rst_qout c=%0d got %h exp 00", c, qout); else n_pass++;
            n_total++; if (wr_valid !== 1'b0) $display("FAIL rst_wr_valid c=%0d got %b exp 0", c, wr_valid); else n_pass++;
        end
        n_total++; if (busy !== 1'b0) $display("FAIL rst_busy got %b exp 0", busy); else n_pass++;
        reset = 1'b1;
        req   = 4'b0000;
        for (int c = 0; c < 5; c++) begin
            tick();
            n_total++; if (qout !== 8'h00) $display("FAIL hold_zero c=%0d got %h exp 00", c, qout); else n_pass++;
        end
        n_total++; if (wr_valid !== 1'b0 || wr_id !== 2'd0) $display("FAIL rst_wr got v=%b id=%0d exp v=0 id=0", wr_valid, wr_id); else n_pass++;
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g;
        logic [7:0] exp_d;
        wdata = 32'h1312_1110;
        req   = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            exp_g = 4'b0001 << (k % 4);
            exp_d = 8'h10 + 8'(k % 4);
            #1;
            n_total++; if (gnt !== exp_g) $display("FAIL rr_gnt k=%0d got %b exp %b", k, gnt, exp_g); else n_pass++;
            n_total++; if (qin !== exp_d) $display("FAIL rr_qin k=%0d got %h exp %h", k, qin, exp_d); else n_pass++;
            tick();
            n_total++; if (qout !== exp_d) $display("FAIL rr_qout k=%0d got %h exp %h", k, qout, exp_d); else n_pass++;
            n_total++; if (wr_valid !== 1'b1 || wr_id !== 2'(k % 4))
                $display("FAIL rr_wr k=%0d got v=%b id=%0d exp v=1 id=%0d", k, wr_valid, wr_id, k % 4); else n_pass++;
        end
        req = 4'b0000;
        tick();
        n_total++; if (wr_valid !== 1'b0) $display("FAIL rr_idle_valid got %b exp 0", wr_valid); else n_pass++;
    endtask

    task automatic test_hold_until_grant();
        // ptr is 1 here; only requester 2 asks.
        wdata = 32'h00A5_0000;
        req   = 4'b0100;
        #1;
        n_total++; if (gnt !== 4'b0100) $display("FAIL hug_gnt got %b exp 0100", gnt); else n_pass++;
        tick();
        req = 4'b0000;
        n_total++; if (qout !== 8'hA5 || wr_valid !== 1'b1 || wr_id !== 2'd2)
            $display("FAIL hug_write got q=%h v=%b id=%0d exp q=a5 v=1 id=2", qout, wr_valid, wr_id); else n_pass++;
        tick();
        n_total++; if (wr_valid !== 1'b0 || wr_id !== 2'd2) $display("FAIL hug_pulse got v=%b id=%0d exp v=0 id=2", wr_valid, wr_id); else n_pass++;
        for (int c = 0; c < 4; c++) begin
            n_total++; if (qout !== 8'hA5) $display("FAIL hug_hold c=%0d got %h exp a5", c, qout); else n_pass++;
            tick();
        end
    endtask

    task automatic test_locked_burst();
        logic [7:0] d1;
        // ptr is 3: requester 1 enters alone, requester 3 joins once the burst has started.
        req  = 4'b0010;
        lock = 4'b0010;
        for (int k = 0; k < 4; k++) begin
            d1    = 8'hB0 + 8'(k);
            wdata = {8'h43, 8'h42, d1, 8'h40};
            #1;
            n_total++; if (gnt !== 4'b0010) $display("FAIL lb_gnt k=%0d got %b exp 0010", k, gnt); else n_pass++;
            n_total++; if (busy !== (k != 0)) $display("FAIL lb_busy k=%0d got %b exp %b", k, busy, k != 0); else n_pass++;
            tick();
            req = 4'b1010;
            n_total++; if (qout !== d1 || wr_id !== 2'd1) $display("FAIL lb_qout k=%0d got q=%h id=%0d exp q=%h id=1", k, qout, wr_id, d1); else n_pass++;
        end
        #1;
        n_total++; if (busy !== 1'b0) $display("FAIL lb_release got busy=%b exp 0", busy); else n_pass++;
        n_total++; if (gnt !== 4'b1000) $display("FAIL lb_next_gnt got %b exp 1000", gnt); else n_pass++;
        tick();
        n_total++; if (qout !== 8'h43 || wr_id !== 2'd3) $display("FAIL lb_q3 got q=%h id=%0d exp q=43 id=3", qout, wr_id); else n_pass++;
        req  = 4'b1011;
        lock = 4'b0000;
        #1;
        n_total++; if (gnt !== 4'b0001) $display("FAIL lb_ptr_gnt got %b exp 0001", gnt); else n_pass++;
        tick();
        n_total++; if (qout !== 8'h40) $display("FAIL lb_q0 got %h exp 40", qout); else n_pass++;
        req = 4'b0000;
    endtask

    task automatic test_early_unlock();
        // ptr is 1: requester 0 wins alone and locks.
        wdata = 32'h0052_0050;
        req   = 4'b0001;
        lock  = 4'b0001;
        #1;
        n_total++; if (gnt !== 4'b0001 || busy !== 1'b0) $display("FAIL eu_first got g=%b b=%b exp g=0001 b=0", gnt, busy); else n_pass++;
        tick();
        n_total++; if (qout !== 8'h50 || busy !== 1'b1) $display("FAIL eu_locked got q=%h b=%b exp q=50 b=1", qout, busy); else n_pass++;
        wdata = 32'h0052_0051;
        req   = 4'b0101;
        lock  = 4'b0000;
        #1;
        n_total++; if (gnt !== 4'b0001) $display("FAIL eu_second_gnt got %b exp 0001", gnt); else n_pass++;
        tick();
        n_total++; if (qout !== 8'h51 || busy !== 1'b0) $display("FAIL eu_exit got q=%h b=%b exp q=51 b=0", qout, busy); else n_pass++;
        #1;
        n_total++; if (gnt !== 4'b0100) $display("FAIL eu_gnt2 got %b exp 0100", gnt); else n_pass++;
        tick();
        n_total++; if (qout !== 8'h52 || wr_id !== 2'd2) $display("FAIL eu_q2 got q=%h id=%0d exp q=52 id=2", qout, wr_id); else n_pass++;
        req = 4'b0000;
    endtask

    task automatic test_reset_mid_burst();
        // ptr is 3: requester 2 wins and locks, leaving ptr at 3.
        wdata = 32'h0062_0000;
        req   = 4'b0100;
        lock  = 4'b0100;
        #1;
        n_total++; if (gnt !== 4'b0100) $display("FAIL rmb_gnt got %b exp 0100", gnt); else n_pass++;
        tick();
        n_total++; if (qout !== 8'h62 || busy !== 1'b1) $display("FAIL rmb_first got q=%h b=%b exp q=62 b=1", qout, busy); else n_pass++;
        req = 4'b0000;
        #1;
        n_total++; if (gnt !== 4'b0000 || busy !== 1'b1) $display("FAIL rmb_park got g=%b b=%b exp g=0000 b=1", gnt, busy); else n_pass++;
        tick();
        n_total++; if (qout !== 8'h62 || wr_valid !== 1'b0 || busy !== 1'b1)
            $display("FAIL rmb_park_hold got q=%h v=%b b=%b exp q=62 v=0 b=1", qout, wr_valid, busy); else n_pass++;
        wdata = 32'h0063_0000;
        req   = 4'b0100;
        reset = 1'b0;
        #1;
        n_total++; if (gnt !== 4'b0000 || qin !== 8'h00) $display("FAIL rmb_rst_comb got g=%b qin=%h exp g=0000 qin=00", gnt, qin); else n_pass++;
        tick();
        n_total++; if (qout !== 8'h00 || busy !== 1'b0 || wr_valid !== 1'b0 || wr_id !== 2'd0)
            $display("FAIL rmb_after got q=%h b=%b v=%b id=%0d exp q=00 b=0 v=0 id=0", qout, busy, wr_valid, wr_id); else n_pass++;
        reset = 1'b1;
        lock  = 4'b0000;
        req   = 4'b1111;
        wdata = 32'h7372_7170;
        #1;
        n_total++; if (gnt !== 4'b0001) $display("FAIL rmb_restart got %b exp 0001", gnt); else n_pass++;
        tick();
        n_total++; if (qout !== 8'h70 || wr_id !== 2'd0) $display("FAIL rmb_restart_q got q=%h id=%0d exp q=70 id=0", qout, wr_id); else n_pass++;
        req = 4'b0000;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        reset   = 1'b0;
        req     = 4'b0000;
        lock    = 4'b0000;
        wdata   = 32'h0;
        #1;
        test_reset();
        test_round_robin();
        test_hold_until_grant();
        test_locked_burst();
        test_early_unlock();
        test_reset_mid_burst();
        tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
